// File: rtl/led_matrix_scan_driver.sv
// Row-multiplexed scan driver for an 8x8 RGB matrix behind four chained 74HC595s.
// Optional macro LED_MATRIX_BLANK_EN: blank the outputs (oe_n=1) everywhere except HOLD.
module led_matrix_scan_driver #(
    parameter int CLK_DIV     = 1,
    parameter int ROW_HOLD    = 1000,
    parameter int INVERT_DATA = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [7:0][23:0] board,
    output logic             ds,
    output logic             shcp,
    output logic             stcp,
    output logic             oe_n,
    output logic [2:0]       row_idx,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_HOLD
    } state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(ROW_HOLD - 1);

    state_t           state_q, state_d;
    logic [7:0]       div_q, div_d;
    logic             phase_q, phase_d;
    logic [4:0]       bit_q, bit_d;
    logic [15:0]      hold_q, hold_d;
    logic [2:0]       row_q, row_d;
    logic [31:0]      shreg_q, shreg_d;
    logic [7:0][23:0] snap_q, snap_d;
    logic [23:0]      row_pix;

    function automatic logic [31:0] build_word(input logic [2:0] row, input logic [23:0] pix);
        logic [7:0] sel;
        sel = 8'b1 << row;
        return {sel, (INVERT_DATA != 0) ? ~pix : pix};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            hold_q  <= '0;
            row_q   <= '0;
            shreg_q <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            row_q   <= row_d;
            shreg_q <= shreg_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        hold_d     = hold_q;
        row_d      = row_q;
        shreg_d    = shreg_q;
        snap_d     = snap_q;
        row_pix    = '0;
        ds         = 1'b0;
        shcp       = 1'b0;
        stcp       = 1'b0;
        frame_done = 1'b0;
`ifdef LED_MATRIX_BLANK_EN
        oe_n       = (state_q != S_HOLD);
`else
        oe_n       = (state_q == S_IDLE);
`endif

        case (state_q)
            S_IDLE: begin
                row_d = '0;
                if (enable) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Row 0 reads the live board so a change coincident with this cycle is captured.
                if (row_q == 3'd0) begin
                    snap_d  = board;
                    row_pix = board[0];
                end else begin
                    row_pix = snap_q[row_q];
                end
                shreg_d = build_word(row_q, row_pix);
                bit_d   = '0;
                div_d   = '0;
                phase_d = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                ds   = shreg_q[31];
                shcp = phase_q;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        shreg_d = {shreg_q[30:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                        if (bit_q == 5'd31) begin
                            state_d = S_LATCH;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_LATCH: begin
                stcp = 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    hold_d  = '0;
                    state_d = S_HOLD;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    frame_done = (row_q == 3'd7);
                    if (enable) begin
                        row_d   = row_q + 3'd1;
                        state_d = S_LOAD;
                    end else begin
                        row_d   = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign row_idx = row_q;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench for led_matrix_scan_driver (CLK_DIV=1, ROW_HOLD=4, INVERT_DATA=1).
module tb_led_matrix_scan_driver;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [7:0][23:0] board;
    logic             ds, shcp, stcp, oe_n, frame_done;
    logic [2:0]       row_idx;

    int total = 0;
    int bad   = 0;

    led_matrix_scan_driver #(
        .CLK_DIV    (1),
        .ROW_HOLD   (4),
        .INVERT_DATA(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .board     (board),
        .ds        (ds),
        .shcp      (shcp),
        .stcp      (stcp),
        .oe_n      (oe_n),
        .row_idx   (row_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          row;
        logic [31:0] word;
        logic        fd;
    } vec_t;

    vec_t vt[14];

    logic [31:0] r_word;
    int          r_rises, r_stcp_cnt, r_stcp_pos, r_fd_cnt, r_fd_pos, r_oe_bad, r_row_bad;
    logic [2:0]  r_row;
    int          idle_bad, idle_rises;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic exp_oe(input int k);
`ifdef LED_MATRIX_BLANK_EN
        return (k >= 66) ? 1'b0 : 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // One row is 70 cycles: k=0 LOAD, 1..64 SHIFT, 65 LATCH, 66..69 HOLD.
    task automatic run_row();
        logic prev;
        prev = 1'b0;
        r_word = '0; r_rises = 0; r_stcp_cnt = 0; r_stcp_pos = 0;
        r_fd_cnt = 0; r_fd_pos = 0; r_oe_bad = 0; r_row_bad = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (k == 0) r_row = row_idx;
            else if (row_idx !== r_row) r_row_bad++;
            if (shcp && !prev) begin
                r_word = {r_word[30:0], ds};
                r_rises++;
            end
            prev = shcp;
            if (stcp) begin r_stcp_cnt++; r_stcp_pos = k; end
            if (frame_done) begin r_fd_cnt++; r_fd_pos = k; end
            if (oe_n !== exp_oe(k)) r_oe_bad++;
        end
    endtask

    task automatic idle_watch(input int n);
        logic prev;
        prev = 1'b0;
        idle_bad = 0; idle_rises = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (shcp && !prev) idle_rises++;
            prev = shcp;
            if (ds !== 1'b0 || shcp !== 1'b0 || stcp !== 1'b0 || frame_done !== 1'b0 ||
                oe_n !== 1'b1 || row_idx !== 3'd0) idle_bad++;
        end
    endtask

    initial begin
        // Frame 1 rows 0..7, then frame 2 rows 0..5 (enable dropped during row 5).
        vt[0]  = '{0, 32'h0100FFFF, 1'b0};
        vt[1]  = '{1, 32'h02FF00FF, 1'b0};
        vt[2]  = '{2, 32'h04FFFF00, 1'b0};
        vt[3]  = '{3, 32'h08FFFFFF, 1'b0};
        vt[4]  = '{4, 32'h10EDCBA9, 1'b0};
        vt[5]  = '{5, 32'h20000000, 1'b0};
        vt[6]  = '{6, 32'h405A5A5A, 1'b0};
        vt[7]  = '{7, 32'h807FFFFE, 1'b1};
        vt[8]  = '{0, 32'h01FF00FF, 1'b0};
        vt[9]  = '{1, 32'h02FF00FF, 1'b0};
        vt[10] = '{2, 32'h04FFFF00, 1'b0};
        vt[11] = '{3, 32'h08FFFF00, 1'b0};
        vt[12] = '{4, 32'h10EDCBA9, 1'b0};
        vt[13] = '{5, 32'h20000000, 1'b0};

        board[0] = 24'hFF0000;
        board[1] = 24'h00FF00;
        board[2] = 24'h0000FF;
        board[3] = 24'h000000;
        board[4] = 24'h123456;
        board[5] = 24'hFFFFFF;
        board[6] = 24'hA5A5A5;
        board[7] = 24'h800001;
        enable   = 1'b0;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_ds",   32'(ds),         32'd0);
        chk("rst_shcp", 32'(shcp),       32'd0);
        chk("rst_stcp", 32'(stcp),       32'd0);
        chk("rst_oe_n", 32'(oe_n),       32'd1);
        chk("rst_row",  32'(row_idx),    32'd0);
        chk("rst_fd",   32'(frame_done), 32'd0);

        @(negedge clk) reset_n = 1'b1;
        idle_watch(20);
        chk("idle_after_rst", 32'(idle_bad),   32'd0);
        chk("idle_rises",     32'(idle_rises), 32'd0);

        enable = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 8) board[0] = 24'h00FF00;
            if (i == 2 || i == 13) begin
                fork
                    run_row();
                    begin
                        repeat (10) @(negedge clk);
                        if (i == 2) board[3] = 24'h0000FF;
                        else enable = 1'b0;
                    end
                join
            end else begin
                run_row();
            end
            chk($sformatf("row_idx[%0d]", i),   32'(r_row),      32'(vt[i].row));
            chk($sformatf("row_stable[%0d]", i), 32'(r_row_bad), 32'd0);
            chk($sformatf("word[%0d]", i),      r_word,          vt[i].word);
            chk($sformatf("rises[%0d]", i),     32'(r_rises),    32'd32);
            chk($sformatf("stcp[%0d]", i),      32'(r_stcp_cnt * 100 + r_stcp_pos), 32'd165);
            chk($sformatf("frame_done[%0d]", i), 32'(r_fd_cnt * 100 + r_fd_pos),
                vt[i].fd ? 32'd169 : 32'd0);
            chk($sformatf("oe_n[%0d]", i),      32'(r_oe_bad),   32'd0);
        end

        idle_watch(30);
        chk("idle_after_drop",  32'(idle_bad),   32'd0);
        chk("idle_drop_rises",  32'(idle_rises), 32'd0);

        // Reset during SHIFT: k=16 is the high phase of bit 24 (the row-0 select bit, =1).
        enable = 1'b1;
        repeat (17) @(negedge clk);
        chk("pre_rst_shcp", 32'(shcp), 32'd1);
        chk("pre_rst_ds",   32'(ds),   32'd1);
        chk("pre_rst_oe_n", 32'(oe_n), 32'(exp_oe(16)));
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ds",   32'(ds),         32'd0);
        chk("mid_rst_shcp", 32'(shcp),       32'd0);
        chk("mid_rst_stcp", 32'(stcp),       32'd0);
        chk("mid_rst_oe_n", 32'(oe_n),       32'd1);
        chk("mid_rst_row",  32'(row_idx),    32'd0);
        chk("mid_rst_fd",   32'(frame_done), 32'd0);
        enable = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        idle_watch(30);
        chk("idle_after_mid_rst", 32'(idle_bad),   32'd0);
        chk("idle_mid_rst_rises", 32'(idle_rises), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
